// File: rtl/reg_bank_read.sv
// ---------------------------------------------------------------------------
// reg_bank_read
//   32x32 general-purpose register bank for the multicycle CPU datapath.
//   One write port (from the write-data mux), two registered read ports
//   (rs/rt, feeding registers A and B) and a sequential dump port that walks
//   all 32 registers for debug inspection. Register SP_INDEX leaves reset
//   holding SP_INIT (stack-pointer constant); register 0 is hard-wired to 0.
//
// Ports
//   clk         in   1   rising-edge clock
//   reset_n     in   1   asynchronous active-low reset
//   reg_write   in   1   write enable
//   write_reg   in   5   write address
//   write_data  in  32   write data
//   read_reg1   in   5   read address, port 1 (rs)
//   read_reg2   in   5   read address, port 2 (rt)
//   read_data1  out 32   registered read data, port 1
//   read_data2  out 32   registered read data, port 2
//   dump_start  in   1   one-cycle pulse starting a full-bank dump
//   dump_busy   out  1   high while a dump is in progress
//   dump_valid  out  1   dump_addr/dump_data valid this cycle
//   dump_addr   out  5   index of the register being dumped
//   dump_data   out 32   contents of register dump_addr
//
// Configuration
//   REG_BANK_BYPASS_EN  when defined, a read (or dump sample) of the address
//                       being written on the same edge captures write_data.
//                       Undefined: the pre-edge register contents are returned.
// ---------------------------------------------------------------------------
module reg_bank_read #(
  parameter logic [31:0] SP_INIT  = 32'd227,
  parameter int          SP_INDEX = 29
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reg_write,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  input  logic        dump_start,
  output logic        dump_busy,
  output logic        dump_valid,
  output logic [4:0]  dump_addr,
  output logic [31:0] dump_data
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] regs_q [32];
  logic [31:0] rd1_q, rd1_d;
  logic [31:0] rd2_q, rd2_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [4:0]  daddr_q, daddr_d;
  logic [31:0] ddata_q, ddata_d;

  logic        wr_en_s;
  logic        hit1_s, hit2_s, hitd_s;

  // Register 0 is never written, which keeps it reading as zero.
  assign wr_en_s = reg_write && (write_reg != 5'd0);

`ifdef REG_BANK_BYPASS_EN
  assign hit1_s = wr_en_s && (read_reg1 == write_reg);
  assign hit2_s = wr_en_s && (read_reg2 == write_reg);
  assign hitd_s = wr_en_s && (cnt_q == write_reg);
`else
  assign hit1_s = 1'b0;
  assign hit2_s = 1'b0;
  assign hitd_s = 1'b0;
`endif

  // Register array: reset image (SP preset) and the single write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? SP_INIT : 32'd0;
      end
    end else if (wr_en_s) begin
      regs_q[write_reg] <= write_data;
    end
  end

  // FSM state, dump counter and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      rd1_q   <= 32'd0;
      rd2_q   <= 32'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      daddr_q <= 5'd0;
      ddata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      daddr_q <= daddr_d;
      ddata_q <= ddata_d;
    end
  end

  // Dump FSM next state. busy_q also covers the cycle showing addr 31,
  // during which the FSM is already IDLE but a new start must be ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dump_start && !busy_q) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == 5'd31) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of read ports, counter and dump outputs.
  always_comb begin
    rd1_d = hit1_s ? write_data : regs_q[read_reg1];
    rd2_d = hit2_s ? write_data : regs_q[read_reg2];
    // Busy rises with entry into RUN and stays through the addr-31 cycle.
    busy_d = (state_d == ST_RUN) || (state_q == ST_RUN);
    if (state_q == ST_RUN) begin
      cnt_d   = cnt_q + 5'd1;   // 31 + 1 wraps to 0
      valid_d = 1'b1;
      daddr_d = cnt_q;
      ddata_d = hitd_s ? write_data : regs_q[cnt_q];
    end else begin
      cnt_d   = 5'd0;
      valid_d = 1'b0;
      daddr_d = 5'd0;
      ddata_d = 32'd0;
    end
  end

  assign read_data1 = rd1_q;
  assign read_data2 = rd2_q;
  assign dump_busy  = busy_q;
  assign dump_valid = valid_q;
  assign dump_addr  = daddr_q;
  assign dump_data  = ddata_q;

endmodule
